// File: rtl/clk_div_sched.sv
// Divided-rate clock-enable scheduler: one clk_en pulse per 2^cur_sel cycles.
// Ratio changes and stop/start are applied only on period boundaries.
module clk_div_sched #(
  parameter int unsigned DIV_STAGES = 3,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned RESET_SEL  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  input  logic             stop_req,
  output logic             clk_en,
  output logic             sel_done,
  output logic [SEL_W-1:0] cur_sel,
  output logic             stopped
);

  typedef enum logic [1:0] {
    RUN,
    PENDING,
    STOPPED
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_STAGES-1:0] cnt_q, cnt_d, term_cnt, cnt_next;
  logic [SEL_W-1:0]      cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]      pend_q, pend_d;
  logic [SEL_W-1:0]      req_sel_clamped;
  logic                  clk_en_q, clk_en_d;
  logic                  sel_done_q, sel_done_d;
  logic                  req_ready_q, req_ready_d;
  logic                  stopped_q, stopped_d;
  logic                  term;
  logic                  accept;

  // Terminal count R-1 is a mask of cur_sel low ones.
  always_comb begin
    term_cnt = '0;
    for (int unsigned i = 0; i < DIV_STAGES; i++) begin
      term_cnt[i] = (i < 32'(cur_sel_q));
    end
  end

  assign term            = (cnt_q == term_cnt);
  assign cnt_next        = term ? '0 : cnt_q + DIV_STAGES'(1);
  assign accept          = req_valid & req_ready_q;
  assign req_sel_clamped = (32'(req_sel) > DIV_STAGES) ? SEL_W'(DIV_STAGES) : req_sel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_sel_d   = cur_sel_q;
    pend_d      = pend_q;
    clk_en_d    = 1'b0;
    sel_done_d  = 1'b0;
    req_ready_d = req_ready_q;
    stopped_d   = stopped_q;
    unique case (state_q)
      RUN: begin
        cnt_d    = cnt_next;
        clk_en_d = term;
        if (term && stop_req) begin
          state_d   = STOPPED;
          stopped_d = 1'b1;
          // A request landing with the stop is applied directly, as in STOPPED.
          if (accept) begin
            cur_sel_d  = req_sel_clamped;
            sel_done_d = 1'b1;
          end
        end else if (accept) begin
          pend_d      = req_sel_clamped;
          req_ready_d = 1'b0;
          state_d     = PENDING;
        end
      end
      PENDING: begin
        cnt_d    = cnt_next;
        clk_en_d = term;
        if (term) begin
          cur_sel_d   = pend_q;
          sel_done_d  = 1'b1;
          req_ready_d = 1'b1;
          if (stop_req) begin
            state_d   = STOPPED;
            stopped_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      STOPPED: begin
        cnt_d = '0;
        if (accept) begin
          cur_sel_d  = req_sel_clamped;
          sel_done_d = 1'b1;
        end
        if (!stop_req) begin
          state_d   = RUN;
          stopped_d = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      cur_sel_q   <= SEL_W'(RESET_SEL);
      pend_q      <= '0;
      clk_en_q    <= 1'b0;
      sel_done_q  <= 1'b0;
      req_ready_q <= 1'b1;
      stopped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_sel_q   <= cur_sel_d;
      pend_q      <= pend_d;
      clk_en_q    <= clk_en_d;
      sel_done_q  <= sel_done_d;
      req_ready_q <= req_ready_d;
      stopped_q   <= stopped_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign sel_done  = sel_done_q;
  assign req_ready = req_ready_q;
  assign cur_sel   = cur_sel_q;
  assign stopped   = stopped_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: directed stimulus queues expected
// clk_en/sel_done events; a negedge monitor pops and compares them.
module tb_clk_div_sched;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, stop_req, req_ready, clk_en, sel_done, stopped;
  logic [1:0] req_sel, cur_sel;
  logic       c_rst_n, c_req_valid, c_stop_req, c_req_ready, c_clk_en, c_sel_done, c_stopped;
  logic [1:0] c_req_sel, c_cur_sel;

  always #5 clk = ~clk;

  clk_div_sched #(.DIV_STAGES(3), .SEL_W(2), .RESET_SEL(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .stop_req(stop_req), .clk_en(clk_en),
    .sel_done(sel_done), .cur_sel(cur_sel), .stopped(stopped)
  );

  clk_div_sched #(.DIV_STAGES(2), .SEL_W(2), .RESET_SEL(2)) u_clamp (
    .clk(clk), .rst_n(c_rst_n), .req_valid(c_req_valid), .req_sel(c_req_sel),
    .req_ready(c_req_ready), .stop_req(c_stop_req), .clk_en(c_clk_en),
    .sel_done(c_sel_done), .cur_sel(c_cur_sel), .stopped(c_stopped)
  );

  typedef struct packed {
    logic [31:0] e;
    logic        ce;
    logic        sd;
    logic [1:0]  sel;
    logic        st;
  } ev_t;

  ev_t exp_q[$];
  int  edge_n  = 0;
  int  base    = 0;
  int  n_tests = 0;
  int  n_fail  = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, expv, edge_n - base);
    end
  endtask

  task automatic push(input int rel, input logic ce, input logic sd,
                      input logic [1:0] sel, input logic st);
    exp_q.push_back('{e: 32'(base + rel), ce: ce, sd: sd, sel: sel, st: st});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int rel);
    while (edge_n < base + rel) step(1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    stop_req  = 1'b0;
    step(2);
    rst_n = 1'b1;
    base  = edge_n;
  endtask

  always @(negedge clk) begin
    if (clk_en === 1'b1 || sel_done === 1'b1) begin
      ev_t o, x;
      o = '{e: 32'(edge_n), ce: clk_en, sd: sel_done, sel: cur_sel, st: stopped};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got edge=%0d ce=%b sd=%b sel=%0d st=%b, required no event",
                 edge_n - base, clk_en, sel_done, cur_sel, stopped);
      end else begin
        x = exp_q.pop_front();
        if (o !== x) begin
          n_fail++;
          $display("FAIL event: got edge=%0d ce=%b sd=%b sel=%0d st=%b, required edge=%0d ce=%b sd=%b sel=%0d st=%b",
                   int'(o.e) - base, o.ce, o.sd, o.sel, o.st,
                   int'(x.e) - base, x.ce, x.sd, x.sel, x.st);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, required finish within 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_sel = 2'd0; stop_req = 1'b0;
    c_rst_n = 1'b0; c_req_valid = 1'b0; c_req_sel = 2'd0; c_stop_req = 1'b0;

    // Reset state and default divide-by-8
    do_reset();
    chk("reset_cur_sel", 32'(cur_sel), 3);
    chk("reset_stopped", 32'(stopped), 0);
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_clk_en", 32'(clk_en), 0);
    chk("reset_sel_done", 32'(sel_done), 0);
    push(8, 1, 0, 3, 0); push(16, 1, 0, 3, 0); push(24, 1, 0, 3, 0);
    goto(25);

    // Ratio 8 -> 2, same-sel on a terminal edge, then 2 -> 1
    do_reset();
    push(8, 1, 1, 1, 0); push(10, 1, 0, 1, 0); push(12, 1, 0, 1, 0); push(14, 1, 0, 1, 0);
    push(16, 1, 0, 1, 0); push(18, 1, 1, 1, 0); push(20, 1, 1, 0, 0);
    for (int i = 21; i <= 24; i++) push(i, 1, 0, 0, 0);
    goto(2);
    req_valid = 1'b1; req_sel = 2'd1;
    step(1);
    req_valid = 1'b0;
    chk("ready_low_after_accept", 32'(req_ready), 0);
    goto(7);
    chk("ready_low_pending", 32'(req_ready), 0);
    chk("sel_old_pending", 32'(cur_sel), 3);
    goto(8);
    chk("ready_back", 32'(req_ready), 1);
    chk("sel_switched", 32'(cur_sel), 1);
    goto(15);
    req_valid = 1'b1; req_sel = 2'd1;
    step(1);
    req_valid = 1'b0;
    goto(17);
    chk("ready_low_term_accept", 32'(req_ready), 0);
    goto(18);
    req_valid = 1'b1; req_sel = 2'd0;
    step(1);
    req_valid = 1'b0;
    goto(24);

    // Stop/restart at ratio 4, request while stopped, stop during PENDING
    do_reset();
    req_valid = 1'b1; req_sel = 2'd2;
    step(1);
    req_valid = 1'b0;
    push(8, 1, 1, 2, 0);
    goto(9);
    stop_req = 1'b1;
    push(12, 1, 0, 2, 1);
    goto(11);
    chk("not_stopped_yet", 32'(stopped), 0);
    goto(12);
    chk("stopped_set", 32'(stopped), 1);
    chk("ready_in_stop", 32'(req_ready), 1);
    goto(19);
    req_valid = 1'b1; req_sel = 2'd2;
    push(20, 0, 1, 2, 1);
    step(1);
    req_valid = 1'b0;
    goto(27);
    stop_req = 1'b0;
    step(1);
    chk("restart_stopped_clr", 32'(stopped), 0);
    push(32, 1, 0, 2, 0); push(36, 1, 0, 2, 0);
    goto(36);
    req_valid = 1'b1; req_sel = 2'd3;
    step(1);
    req_valid = 1'b0;
    stop_req = 1'b1;
    push(40, 1, 1, 3, 1);
    goto(40);
    chk("stop_in_pending", 32'(stopped), 1);
    chk("sel_in_pending_stop", 32'(cur_sel), 3);
    chk("ready_after_pending_stop", 32'(req_ready), 1);
    goto(43);
    stop_req = 1'b0; req_valid = 1'b1; req_sel = 2'd0;
    push(44, 0, 1, 0, 0);
    push(45, 1, 0, 0, 0); push(46, 1, 0, 0, 0); push(47, 1, 0, 0, 0);
    step(1);
    req_valid = 1'b0;
    chk("restart_with_req", 32'(stopped), 0);
    goto(47);

    // Reset during PENDING, then a cancelled stop
    do_reset();
    goto(1);
    req_valid = 1'b1; req_sel = 2'd0;
    step(1);
    req_valid = 1'b0;
    goto(4);
    chk("mid_pending_ready", 32'(req_ready), 0);
    rst_n = 1'b0;
    step(1);
    chk("midrst_cur_sel", 32'(cur_sel), 3);
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_stopped", 32'(stopped), 0);
    chk("midrst_clk_en", 32'(clk_en), 0);
    chk("midrst_sel_done", 32'(sel_done), 0);
    rst_n = 1'b1;
    base = edge_n;
    push(8, 1, 0, 3, 0); push(16, 1, 0, 3, 0);
    goto(2);
    stop_req = 1'b1;
    goto(5);
    stop_req = 1'b0;
    goto(17);
    chk("stop_cancel", 32'(stopped), 0);

    // Clamp on a DIV_STAGES=2 instance
    rst_n = 1'b0;
    step(2);
    c_rst_n = 1'b1;
    base = edge_n;
    chk("clamp_reset_sel", 32'(c_cur_sel), 2);
    c_req_valid = 1'b1; c_req_sel = 2'd3;
    step(1);
    c_req_valid = 1'b0;
    goto(3);
    chk("clamp_no_done_early", 32'(c_sel_done), 0);
    goto(4);
    chk("clamp_cur_sel", 32'(c_cur_sel), 2);
    chk("clamp_sel_done", 32'(c_sel_done), 1);
    chk("clamp_clk_en", 32'(c_clk_en), 1);
    step(2);

    chk("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
# clk_div_sched

Single-clock divided-rate scheduler that replaces ripple-divided derived clocks with a one-cycle clock-enable pulse at a runtime-selectable ratio of 2^sel (1, 2, 4 or 8 by default, matching the 3-stage divider chain). It sits between the PLL output clock domain and rate-reduced logic, such as processor-core and peripheral enables. It sequences ratio changes and clock stop/start so that they take effect only on divided-period boundaries and never produce a truncated period.

## Interface
- DIV_STAGES, 3: maximum log2 ratio; the sel value is clamped to this.
- SEL_W, 2: width of the select fields.
- RESET_SEL, 3: ratio select loaded at reset (divide by 8).
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  1  ratio-change request.
- req_sel  in  SEL_W  requested log2 ratio; values > DIV_STAGES clamp to DIV_STAGES.
- req_ready  out  1  request can be accepted.
- stop_req  in  1  level; high requests the enable stream to halt at the next period boundary.
- clk_en  out  1  registered one-cycle enable, once per divided period.
- sel_done  out  1  one-cycle pulse when an accepted ratio becomes active.
- cur_sel  out  SEL_W  active log2 ratio.
- stopped  out  1  high while halted.

## Operation
- Counter cnt has width DIV_STAGES. R = 2^cur_sel. The terminal condition is cnt == R-1, which is always true for R=1.
- Reset (rst_n low at an edge) sets the following:
  - cnt=0, cur_sel=RESET_SEL, state RUN, pending register cleared.
  - Outputs: clk_en=0, sel_done=0, req_ready=1, stopped=0.
  - Any in-flight request is discarded.
- States are RUN, PENDING and STOPPED.
- **RUN:**
  - cnt increments each edge and wraps to 0 at terminal.
  - clk_en is registered high for the cycle after each terminal edge.
  - A handshake (req_valid & req_ready at an edge) latches the clamped req_sel into pending. On that edge req_ready goes 0 and the state moves to PENDING.
  - Terminal with stop_req=1: clk_en is still issued for this terminal, cnt goes to 0, the state moves to STOPPED, and stopped goes to 1.
- **PENDING:**
  - Counting and clk_en behave as in RUN, at the old R.
  - On the next terminal edge the following happen together:
    - clk_en is issued, at the old ratio.
    - cur_sel becomes pending and cnt goes to 0.
    - sel_done pulses for one cycle and req_ready returns to 1.
    - The state moves to RUN, or to STOPPED if stop_req=1.
  - A handshake on a terminal edge in RUN does not use that terminal. It applies at the following terminal.
- **STOPPED:**
  - cnt is held at 0 and clk_en stays 0.
  - req_ready=1. An accepted request updates cur_sel on the next edge, sel_done pulses, and the state stays STOPPED.
  - stop_req=0 at an edge moves the state to RUN and sets stopped to 0 at that edge. Counting restarts from 0.
  - A request accepted on the same edge as stop_req falls takes effect on that edge, and the new R counts from restart.
- A request with sel equal to cur_sel still completes the full handshake and still pulses sel_done.
- stop_req deasserting before a terminal in RUN or PENDING cancels the stop, with no effect.

## Timing
- After reset release, with ratio R, clk_en is high in the cycle following edges R, 2R, 3R, and so on. This is exactly 1 cycle in every R.
- With R=1, clk_en is continuously high from the cycle after the first edge.
- Ratio-change latency runs from acceptance to sel_done, and equals the edges remaining to the current terminal, between 1 and R_old.
- The first clk_en at the new ratio comes R_new edges after the sel_done edge.
- The restart from STOPPED to the first clk_en takes R edges after the edge on which stop_req was sampled low.
- clk_en, sel_done, stopped and req_ready are all registered, with no combinational path from inputs to outputs.
- The gap between consecutive clk_en pulses is never shorter than min(R_old, R_new) cycles.

## Test plan
- **Reset and default ratio:** Release reset with RESET_SEL=3 -> clk_en high in the cycles after edges 8, 16 and 24; cur_sel=3; stopped=0; req_ready=1.
- **Ratio change 8 to 2:** Accept req_sel=1 at edge 3 -> clk_en and sel_done after edge 8, then clk_en after edges 10, 12 and 14; req_ready low during edges 4 to 8.
- **Clamp, repeat and simultaneous terminal:**
  - req_sel=3 with DIV_STAGES=2 -> cur_sel=2.
  - A same-sel request still pulses sel_done.
  - A request accepted exactly on a terminal edge switches at the next terminal, not the current one.
- **Stop and restart:**
  - At ratio 4, raise stop_req at edge 2 -> the final clk_en comes after edge 4, then stopped=1 with no clk_en.
  - Drop stop_req at edge 20 -> stopped=0 after edge 20, and the next clk_en comes after edge 24.
- **Request while stopped and stop during PENDING:**
  - Request while STOPPED -> cur_sel updates and sel_done pulses on the next edge, with no clk_en.
  - stop_req during PENDING -> sel switches and the block stops on the same terminal edge.
- **Reset mid-operation:** Assert rst_n=0 during PENDING -> the pending request is dropped, and cur_sel=RESET_SEL, cnt=0 and all outputs are at their reset values after the reset edge.
